// File: rtl/game_pkg.sv
// Types and constants shared by the player motion block and the sprite renderer.
package game_pkg;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } facing_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_W = 8'h1A;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Frame-rate sprite state: facing direction and walk-cycle frame, updated only at vsync_start.
module sprite_anim_ctrl
    import game_pkg::*;
#(
    parameter int unsigned ANIM_FRAMES = 4,
    parameter int unsigned ANIM_DIV    = 6,
    localparam int unsigned FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          vsync_start,
    input  logic [7:0]    keycode,
    output facing_t       facing,
    output logic [FW-1:0] anim_frame
);

    localparam int unsigned DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic          walking;
    logic [DW-1:0] div_cnt, div_cnt_next;
    logic [FW-1:0] anim_next;
    facing_t       facing_next;

    always_comb begin
        walking      = (keycode == KEY_A) || (keycode == KEY_D);
        facing_next  = facing;
        div_cnt_next = div_cnt;
        anim_next    = anim_frame;

        if (keycode == KEY_A) begin
            facing_next = LEFT;
        end else if (keycode == KEY_D) begin
            facing_next = RIGHT;
        end

        // Standing still snaps back to the idle pose at frame 0.
        if (walking) begin
            if (div_cnt == DW'(ANIM_DIV - 1)) begin
                div_cnt_next = '0;
                anim_next    = anim_frame + FW'(1);
            end else begin
                div_cnt_next = div_cnt + DW'(1);
            end
        end else begin
            div_cnt_next = '0;
            anim_next    = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            facing     <= RIGHT;
            div_cnt    <= '0;
            anim_frame <= '0;
        end else if (vsync_start) begin
            facing     <= facing_next;
            div_cnt    <= div_cnt_next;
            anim_frame <= anim_next;
        end
    end

endmodule

// File: rtl/player_sprite_renderer.sv
// Per-pixel player sprite lookup: frame-latched position, ROM address generation and a
// fixed 2-Clk pipeline from DrawX/DrawY to sprite_on/palette_idx.
module player_sprite_renderer
    import game_pkg::*;
#(
    parameter int unsigned SPR_W       = 32,
    parameter int unsigned SPR_H       = 32,
    parameter int unsigned ANIM_FRAMES = 4,
    parameter int unsigned ANIM_DIV    = 6,
    parameter logic [9:0]  X_RESET     = 10'd320,
    parameter logic [9:0]  Y_RESET     = 10'd400,
    parameter logic [3:0]  TRANSPARENT = 4'h0,
    localparam int unsigned ADDR_W = $clog2(ANIM_FRAMES * SPR_W * SPR_H)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vsync_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        BallX,
    input  logic [9:0]        BallY,
    input  logic [7:0]        keycode,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              sprite_on,
    output logic [3:0]        palette_idx
);

    localparam int unsigned FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int unsigned CW = $clog2(SPR_W);
    localparam int unsigned RW = $clog2(SPR_H);

    logic [9:0]    shadow_x, shadow_y;
    facing_t       facing;
    logic [FW-1:0] anim_frame;

    sprite_anim_ctrl #(
        .ANIM_FRAMES (ANIM_FRAMES),
        .ANIM_DIV    (ANIM_DIV)
    ) u_anim_ctrl (
        .Clk         (Clk),
        .Reset       (Reset),
        .vsync_start (vsync_start),
        .keycode     (keycode),
        .facing      (facing),
        .anim_frame  (anim_frame)
    );

    // Position is sampled once per frame so a mid-frame move cannot tear the sprite.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow_x <= X_RESET;
            shadow_y <= Y_RESET;
        end else if (vsync_start) begin
            shadow_x <= BallX;
            shadow_y <= BallY;
        end
    end

    logic [10:0]   dx, dy;
    logic          in_box;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // 11-bit offsets: bit 10 set means left of / above the box, so edges clip instead of wrap.
    always_comb begin
        dx     = {1'b0, DrawX} - {1'b0, shadow_x} + 11'(SPR_W / 2);
        dy     = {1'b0, DrawY} - {1'b0, shadow_y} + 11'(SPR_H / 2);
        in_box = !dx[10] && (dx < 11'(SPR_W)) && !dy[10] && (dy < 11'(SPR_H));
        row    = dy[RW-1:0];
        col    = (facing == LEFT) ? (CW'(SPR_W - 1) - dx[CW-1:0]) : dx[CW-1:0];
    end

    logic       v1;
    logic       sprite_on_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            v1       <= 1'b0;
        end else begin
            if (in_box) begin
                rom_addr <= {anim_frame, row, col};
            end
            v1 <= in_box;
        end
    end

    assign sprite_on_next = v1 && (rom_data != TRANSPARENT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sprite_on   <= 1'b0;
            palette_idx <= 4'h0;
        end else begin
            sprite_on   <= sprite_on_next;
            palette_idx <= sprite_on_next ? rom_data : 4'h0;
        end
    end

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Directed bench for player_sprite_renderer with a reference model and an output scoreboard.
module tb_player_sprite_renderer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        vsync_start;
    logic [9:0]  DrawX, DrawY, BallX, BallY;
    logic [7:0]  keycode;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data;
    logic        sprite_on;
    logic [3:0]  palette_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clk = ~Clk;

    player_sprite_renderer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .vsync_start (vsync_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .BallX       (BallX),
        .BallY       (BallY),
        .keycode     (keycode),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sprite_on   (sprite_on),
        .palette_idx (palette_idx)
    );

    // Sprite ROM contents: transparent whenever the low three address bits are zero.
    function automatic logic [3:0] rom_f(input logic [11:0] a);
        return (a[2:0] == 3'd0) ? 4'h0 : {1'b1, a[2:0] ^ {a[11:10], a[5]}};
    endfunction

    // The ROM's address register is rom_addr itself, so data follows it within the cycle.
    assign rom_data = rom_f(rom_addr);

    typedef struct packed {
        logic       on;
        logic [3:0] pal;
    } exp_t;

    exp_t q[$];

    int          m_sx, m_sy, m_anim, m_div;
    logic        m_left;
    logic [11:0] m_addr;
    logic [11:0] prev_addr;
    int          chg;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sx   = 320;
        m_sy   = 400;
        m_left = 1'b0;
        m_anim = 0;
        m_div  = 0;
        m_addr = 12'h000;
    endtask

    // One Clk: drive a pixel, predict, advance, then check rom_addr and the output stage.
    task automatic drive(input int x, input int y, input logic vs);
        exp_t        e;
        int          dx, dy, col;
        logic        in;
        logic [11:0] a;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        vsync_start = vs;
        if (Reset) begin
            q.delete();
            e = '{on: 1'b0, pal: 4'h0};
            q.push_back(e);
        end else begin
            dx  = x - m_sx + 16;
            dy  = y - m_sy + 16;
            in  = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
            col = m_left ? 31 - dx : dx;
            a   = 12'((m_anim % 4) * 1024 + (dy % 32) * 32 + (col % 32));
            if (in) m_addr = a;
            e.on  = in && (rom_f(a) != 4'h0);
            e.pal = e.on ? rom_f(a) : 4'h0;
            q.push_back(e);
        end
        @(posedge Clk);
        #1;
        if (Reset) begin
            model_reset();
        end else if (vs) begin
            m_sx = int'(BallX);
            m_sy = int'(BallY);
            if (keycode == 8'h04) m_left = 1'b1;
            else if (keycode == 8'h07) m_left = 1'b0;
            if (keycode == 8'h04 || keycode == 8'h07) begin
                if (m_div == 5) begin
                    m_div  = 0;
                    m_anim = (m_anim + 1) % 4;
                end else begin
                    m_div++;
                end
            end else begin
                m_div  = 0;
                m_anim = 0;
            end
        end
        chk("rom_addr", 16'(rom_addr), 16'(m_addr));
        if (Reset) begin
            chk("rst_sprite_on", 16'(sprite_on), 16'h0);
            chk("rst_palette", 16'(palette_idx), 16'h0);
        end else if (q.size() >= 2) begin
            e = q.pop_front();
            chk("sprite_on", 16'(sprite_on), 16'(e.on));
            chk("palette_idx", 16'(palette_idx), 16'(e.pal));
        end
        if (rom_addr !== prev_addr) chg++;
        prev_addr   = rom_addr;
        vsync_start = 1'b0;
    endtask

    initial begin
        Reset       = 1'b1;
        vsync_start = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        BallX       = 10'd320;
        BallY       = 10'd400;
        keycode     = 8'h00;
        prev_addr   = 12'h000;
        chg         = 0;
        model_reset();

        // Reset state
        drive(0, 0, 1'b0);
        drive(0, 0, 1'b0);
        Reset = 1'b0;

        // Idle sprite at 320/400, full box plus a margin
        drive(0, 0, 1'b1);
        for (int y = 382; y <= 417; y++) begin
            for (int x = 302; x <= 337; x++) drive(x, y, 1'b0);
        end
        drive(304, 384, 1'b0);
        chk("addr_top_left", 16'(rom_addr), 16'h000);
        drive(335, 415, 1'b0);
        chk("addr_bot_right", 16'(rom_addr), 16'h3FF);

        // Facing: A mirrors, D restores
        keycode = 8'h04;
        drive(0, 0, 1'b1);
        drive(304, 384, 1'b0);
        chk("mirror_left", 16'(rom_addr), 16'h01F);
        keycode = 8'h07;
        drive(0, 0, 1'b1);
        drive(304, 384, 1'b0);
        chk("face_right", 16'(rom_addr), 16'h000);

        // Walk cycle: one frame step per six vsyncs
        keycode = 8'h00;
        drive(0, 0, 1'b1);
        keycode = 8'h07;
        for (int k = 1; k <= 24; k++) begin
            drive(0, 0, 1'b1);
            drive(304, 384, 1'b0);
            chk("anim_frame", 16'(rom_addr[11:10]), 16'((k / 6) % 4));
        end
        keycode = 8'h00;
        drive(0, 0, 1'b1);
        drive(304, 385, 1'b0);
        chk("anim_idle", 16'(rom_addr), 16'h020);

        // Left screen edge: columns 0..20 only
        BallX = 10'd5;
        BallY = 10'd240;
        drive(0, 0, 1'b1);
        chg = 0;
        for (int x = 0; x < 640; x++) drive(x, 240, 1'b0);
        chk("edge_x_hits", 16'(chg), 16'd21);
        chk("edge_x_last", 16'(rom_addr), 16'h21F);

        // Top edge sprite must not wrap to the bottom rows
        BallY = 10'd3;
        drive(0, 0, 1'b1);
        chg = 0;
        for (int y = 475; y < 480; y++) begin
            for (int x = 0; x < 640; x++) drive(x, y, 1'b0);
        end
        chk("edge_y_hits", 16'(chg), 16'd0);

        // Mid-frame move is ignored until vsync
        BallX = 10'd320;
        BallY = 10'd400;
        drive(0, 0, 1'b1);
        drive(305, 384, 1'b0);
        chk("pre_move", 16'(rom_addr), 16'h001);
        BallX = 10'd100;
        drive(304, 384, 1'b0);
        chk("mid_frame_hold", 16'(rom_addr), 16'h000);
        drive(84, 385, 1'b0);
        chk("mid_frame_no_hit", 16'(rom_addr), 16'h000);
        drive(310, 390, 1'b1);
        chk("vsync_old_pos", 16'(rom_addr), 16'h0C6);
        drive(84, 385, 1'b0);
        chk("new_pos", 16'(rom_addr), 16'h020);
        for (int x = 84; x <= 116; x++) drive(x, 386, 1'b0);

        // Reset mid-sprite with facing LEFT
        keycode = 8'h04;
        drive(0, 0, 1'b1);
        for (int x = 84; x <= 95; x++) drive(x, 387, 1'b0);
        Reset = 1'b1;
        drive(90, 387, 1'b0);
        Reset = 1'b0;
        keycode = 8'h00;
        drive(305, 385, 1'b0);
        chk("post_reset_pos", 16'(rom_addr), 16'h021);
        for (int x = 300; x <= 340; x++) drive(x, 390, 1'b0);
        drive(0, 0, 1'b0);
        drive(0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
